// File: rtl/seq_arith_unit_if.sv
// Operand/result handshake bundle for seq_arith_unit.
// slave = arithmetic unit side, master = producer/consumer side.
interface seq_arith_unit_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic                 op_err;
    logic                 busy;

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, op_err, busy
    );

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, op_err, busy
    );
endinterface

// File: rtl/seq_arith_unit.sv
// Handshaked unsigned add (1 cycle) / shift-add multiply (WIDTH cycles), registered result.
// Define SEQ_ARITH_MAC_EN to add the accumulator with MAC (op=10) and CLR (op=11).
module seq_arith_unit #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_arith_unit_if.slave bus
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_MUL = 2'b01, OP_MAC = 2'b10, OP_CLR = 2'b11} op_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [RW-1:0]    prod_q, prod_d;
    logic [RW-1:0]    result_q, result_d;
    logic             op_err_q, op_err_d;
    logic [RW-1:0]    prod_next;
    logic [WIDTH:0]   sum;
    logic             accept;
`ifdef SEQ_ARITH_MAC_EN
    logic [RW-1:0]    acc_q, acc_d;
    logic             mac_q, mac_d;
`endif

    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == MUL);
    assign bus.result    = result_q;
    assign bus.op_err    = op_err_q;
    assign accept        = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        result_d  = result_q;
        op_err_d  = op_err_q;
`ifdef SEQ_ARITH_MAC_EN
        acc_d     = acc_q;
        mac_d     = mac_q;
`endif
        sum       = {1'b0, bus.a} + {1'b0, bus.b};
        prod_next = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

        case (state_q)
            MUL: begin
                prod_d   = prod_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    op_err_d = 1'b0;
`ifdef SEQ_ARITH_MAC_EN
                    if (mac_q) begin
                        acc_d    = acc_q + prod_next;
                        result_d = acc_q + prod_next;
                    end else begin
                        result_d = prod_next;
                    end
`else
                    result_d = prod_next;
`endif
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: ;
        endcase

        // A new accept (IDLE, or DONE with the beat leaving) overrides the DONE->IDLE exit.
        if (accept) begin
            case (op_e'(bus.op))
                OP_ADD: begin
                    result_d = RW'(sum);
                    op_err_d = 1'b0;
                    state_d  = DONE;
                end
                OP_MUL: begin
                    mcand_d  = RW'(bus.a);
                    mplier_d = bus.b;
                    prod_d   = '0;
                    cnt_d    = '0;
                    state_d  = MUL;
`ifdef SEQ_ARITH_MAC_EN
                    mac_d    = 1'b0;
`endif
                end
`ifdef SEQ_ARITH_MAC_EN
                OP_MAC: begin
                    mcand_d  = RW'(bus.a);
                    mplier_d = bus.b;
                    prod_d   = '0;
                    cnt_d    = '0;
                    state_d  = MUL;
                    mac_d    = 1'b1;
                end
                OP_CLR: begin
                    acc_d    = '0;
                    result_d = '0;
                    op_err_d = 1'b0;
                    state_d  = DONE;
                end
`endif
                default: begin
                    result_d = '0;
                    op_err_d = 1'b1;
                    state_d  = DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            result_q <= '0;
            op_err_q <= 1'b0;
`ifdef SEQ_ARITH_MAC_EN
            acc_q    <= '0;
            mac_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            op_err_q <= op_err_d;
`ifdef SEQ_ARITH_MAC_EN
            acc_q    <= acc_d;
            mac_q    <= mac_d;
`endif
        end
    end
endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed bench for seq_arith_unit (WIDTH=8) with an expected-result queue checked on every transfer.
module tb_seq_arith_unit;
    typedef struct {
        logic [15:0] res;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    exp_t sb[$];
    exp_t e_mon;

    seq_arith_unit_if #(.WIDTH(8)) bus ();

    seq_arith_unit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every transfer must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL sb_underflow: observed beat 0x%0h expected none", bus.result);
            end else begin
                e_mon = sb.pop_front();
                chk("sb_result", {16'h0, bus.result}, {16'h0, e_mon.res});
                chk("sb_op_err", {31'h0, bus.op_err}, {31'h0, e_mon.err});
            end
        end
    end

    task automatic push(input logic [15:0] r, input logic er);
        exp_t e;
        e.res = r;
        e.err = er;
        sb.push_back(e);
    endtask

    // Presents a beat and returns 1 time unit after the edge that accepted it.
    task automatic send(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.a        = x;
        bus.b        = y;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_cmp++;
            n_fail++;
            $error("FAIL accept_timeout: observed in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op       = 2'($urandom);
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
    endtask

    // Counts clock edges after the accept edge until out_valid; ends on a negedge.
    task automatic wait_valid(input int exp_edges, input bit check_busy);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.out_valid && n < 64) begin
            if (check_busy) begin
                chk("busy_during_mul", {31'h0, bus.busy}, 32'd1);
                chk("in_ready_during_mul", {31'h0, bus.in_ready}, 32'd0);
            end
            @(negedge clk);
            n++;
        end
        chk("latency", n, exp_edges);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                          input logic [15:0] r, input logic er, input int edges);
        push(r, er);
        send(o, x, y);
        wait_valid(edges, edges > 0);
        @(posedge clk);
        #1;
        chk("single_beat", {31'h0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.op       = 2'b00;
        bus.a        = '0;
        bus.b        = '0;
        bus.out_ready = 1'b1;

        #2;
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'h0, bus.busy}, 32'd0);
        chk("rst_result", {16'h0, bus.result}, 32'd0);
        chk("rst_op_err", {31'h0, bus.op_err}, 32'd0);
        chk("rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(2'b00, 8'd255, 8'd255, 16'h01FE, 1'b0, 0);
        run_op(2'b01, 8'd255, 8'd255, 16'hFE01, 1'b0, 8);
        run_op(2'b01, 8'd0,   8'd77,  16'h0000, 1'b0, 8);
        run_op(2'b00, 8'd0,   8'd0,   16'h0000, 1'b0, 0);

        // Stalled MUL result, then released together with a back-to-back ADD.
        bus.out_ready = 1'b0;
        push(16'd156, 1'b0);
        send(2'b01, 8'd12, 8'd13);
        wait_valid(8, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'h0, bus.out_valid}, 32'd1);
            chk("stall_result", {16'h0, bus.result}, 32'd156);
            chk("stall_in_ready", {31'h0, bus.in_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        push(16'd3, 1'b0);
        send(2'b00, 8'd1, 8'd2);
        chk("b2b_valid", {31'h0, bus.out_valid}, 32'd1);
        chk("b2b_result", {16'h0, bus.result}, 32'd3);
        @(posedge clk);
        #1;
        chk("b2b_single_beat", {31'h0, bus.out_valid}, 32'd0);

        // Reset in the middle of an iteration discards the operation.
        send(2'b01, 8'd100, 8'd200);
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", {31'h0, bus.busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
        chk("mid_rst_busy", {31'h0, bus.busy}, 32'd0);
        chk("mid_rst_result", {16'h0, bus.result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(2'b01, 8'd3, 8'd7, 16'd21, 1'b0, 8);

`ifdef SEQ_ARITH_MAC_EN
        run_op(2'b11, 8'd0,   8'd0,   16'h0000, 1'b0, 0);
        run_op(2'b10, 8'd10,  8'd20,  16'd200,  1'b0, 8);
        run_op(2'b10, 8'd3,   8'd4,   16'd212,  1'b0, 8);
        run_op(2'b11, 8'd9,   8'd9,   16'h0000, 1'b0, 0);
        run_op(2'b10, 8'd255, 8'd255, 16'hFE01, 1'b0, 8);
        run_op(2'b10, 8'd255, 8'd255, 16'hFC02, 1'b0, 8);
`else
        run_op(2'b10, 8'd10, 8'd20, 16'h0000, 1'b1, 0);
        run_op(2'b00, 8'd4,  8'd5,  16'd9,    1'b0, 0);
        run_op(2'b11, 8'd6,  8'd7,  16'h0000, 1'b1, 0);
`endif
        run_op(2'b00, 8'd200, 8'd100, 16'd300, 1'b0, 0);

        repeat (3) @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);
        chk("idle_out_valid", {31'h0, bus.out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
